// File: rtl/lcd_refresh_ctrl.sv
// rtl/lcd_refresh_ctrl.sv - HD44780 16x2 refresh sequencer: init list, then endless line-1/line-2 character copy.
// Define LCD_NIBBLE_MODE_EN for the 4-bit bus variant (data on lcd_db[7:4], high nibble first).
module lcd_refresh_ctrl #(
  parameter int CLK_DIV        = 25,
  parameter int CMD_WAIT       = 2500,
  parameter int CLEAR_WAIT     = 100000,
  parameter int POWERUP_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] buf_sel,
  input  logic [7:0] buf_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db,
  output logic       init_done,
  output logic       frame_done
);

  localparam int MAX_W = (CMD_WAIT > CLEAR_WAIT) ? CMD_WAIT : CLEAR_WAIT;
  localparam int MAX_P = (POWERUP_CYCLES > CLK_DIV) ? POWERUP_CYCLES : CLK_DIV;
  localparam int MAX_C = (MAX_W > MAX_P) ? MAX_W : MAX_P;
  localparam int CW    = $clog2(MAX_C + 1);

`ifdef LCD_NIBBLE_MODE_EN
  localparam bit         NIBBLE    = 1'b1;
  localparam logic [3:0] INIT_LAST = 4'd9;

  // {single_nibble, byte}; single-nibble entries carry their nibble in [7:4]
  function automatic logic [8:0] init_entry(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: init_entry = {1'b1, 8'h30};
      4'd3:             init_entry = {1'b1, 8'h20};
      4'd4, 4'd5, 4'd6: init_entry = {1'b0, 8'h28};
      4'd7:             init_entry = {1'b0, 8'h0C};
      4'd8:             init_entry = {1'b0, 8'h01};
      default:          init_entry = {1'b0, 8'h06};
    endcase
  endfunction
`else
  localparam bit         NIBBLE    = 1'b0;
  localparam logic [3:0] INIT_LAST = 4'd5;

  function automatic logic [8:0] init_entry(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: init_entry = {1'b0, 8'h38};
      4'd3:             init_entry = {1'b0, 8'h0C};
      4'd4:             init_entry = {1'b0, 8'h01};
      default:          init_entry = {1'b0, 8'h06};
    endcase
  endfunction
`endif

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_ADDR, S_FETCH, S_WRITE} state_t;
  typedef enum logic [1:0] {P_SETUP, P_HIGH, P_HOLD, P_WAIT} phase_t;

  state_t        r_state, w_state_nxt;
  phase_t        r_phase, w_phase_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_init_idx, w_init_idx_nxt;
  logic [4:0]    r_char_idx, w_char_idx_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_single, w_single_nxt;
  logic          r_nib_lo, w_nib_lo_nxt;
  logic [4:0]    r_sel, w_sel_nxt;
  logic          r_e, w_e_nxt;
  logic          r_rs, w_rs_nxt;
  logic [7:0]    r_db, w_db_nxt;
  logic          r_init_done, w_init_done_nxt;
  logic          r_frame_done, w_frame_done_nxt;

  logic [31:0]   w_wait_len;
  logic [31:0]   w_len;
  logic          w_last;
  logic          w_wr_done;
  logic          w_load;
  logic [7:0]    w_load_byte;
  logic          w_load_rs;
  logic          w_load_single;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_PWRUP;
      r_phase      <= P_SETUP;
      r_cnt        <= '0;
      r_init_idx   <= '0;
      r_char_idx   <= '0;
      r_byte       <= '0;
      r_single     <= 1'b0;
      r_nib_lo     <= 1'b0;
      r_sel        <= '0;
      r_e          <= 1'b0;
      r_rs         <= 1'b0;
      r_db         <= '0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_cnt        <= w_cnt_nxt;
      r_init_idx   <= w_init_idx_nxt;
      r_char_idx   <= w_char_idx_nxt;
      r_byte       <= w_byte_nxt;
      r_single     <= w_single_nxt;
      r_nib_lo     <= w_nib_lo_nxt;
      r_sel        <= w_sel_nxt;
      r_e          <= w_e_nxt;
      r_rs         <= w_rs_nxt;
      r_db         <= w_db_nxt;
      r_init_done  <= w_init_done_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_wait_len = (r_state == S_INIT && r_byte == 8'h01) ? 32'(CLEAR_WAIT) : 32'(CMD_WAIT);
    if (r_state == S_PWRUP)
      w_len = 32'(POWERUP_CYCLES);
    else if (r_phase == P_WAIT)
      w_len = w_wait_len;
    else
      w_len = 32'(CLK_DIV);
    w_last = (32'(r_cnt) + 32'd1 >= w_len);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_cnt_nxt        = r_cnt + 1'b1;
    w_init_idx_nxt   = r_init_idx;
    w_char_idx_nxt   = r_char_idx;
    w_byte_nxt       = r_byte;
    w_single_nxt     = r_single;
    w_nib_lo_nxt     = r_nib_lo;
    w_sel_nxt        = r_sel;
    w_e_nxt          = r_e;
    w_rs_nxt         = r_rs;
    w_db_nxt         = r_db;
    w_init_done_nxt  = r_init_done;
    w_frame_done_nxt = 1'b0;
    w_wr_done        = 1'b0;
    w_load           = 1'b0;
    w_load_byte      = 8'h00;
    w_load_rs        = 1'b0;
    w_load_single    = 1'b0;

    case (r_state)
      S_PWRUP: begin
        if (w_last) begin
          w_state_nxt                   = S_INIT;
          w_load                        = 1'b1;
          {w_load_single, w_load_byte}  = init_entry(4'd0);
        end
      end
      S_FETCH: begin
        w_state_nxt = S_WRITE;
        w_load      = 1'b1;
        w_load_byte = buf_data;
        w_load_rs   = 1'b1;
      end
      default: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          case (r_phase)
            P_SETUP: begin
              w_phase_nxt = P_HIGH;
              w_e_nxt     = 1'b1;
            end
            P_HIGH: begin
              w_phase_nxt = P_HOLD;
              w_e_nxt     = 1'b0;
            end
            P_HOLD: begin
              // Full bytes on a 4-bit bus get a second strobe for the low nibble before any WAIT
              if (NIBBLE && !r_nib_lo && !r_single) begin
                w_nib_lo_nxt = 1'b1;
                w_phase_nxt  = P_SETUP;
                w_db_nxt     = {r_byte[3:0], 4'h0};
              end else if (w_wait_len == 32'd0) begin
                w_wr_done = 1'b1;
              end else begin
                w_phase_nxt = P_WAIT;
              end
            end
            default: w_wr_done = 1'b1;
          endcase
        end
      end
    endcase

    if (w_wr_done) begin
      case (r_state)
        S_INIT: begin
          if (r_init_idx == INIT_LAST) begin
            w_init_done_nxt = 1'b1;
            w_state_nxt     = S_ADDR;
            w_load          = 1'b1;
            w_load_byte     = 8'h80;
          end else begin
            w_init_idx_nxt               = r_init_idx + 4'd1;
            w_load                       = 1'b1;
            {w_load_single, w_load_byte} = init_entry(r_init_idx + 4'd1);
          end
        end
        S_ADDR: begin
          w_state_nxt = S_FETCH;
          w_sel_nxt   = r_char_idx;
        end
        default: begin
          w_char_idx_nxt = r_char_idx + 5'd1;
          if (r_char_idx == 5'd15) begin
            w_state_nxt = S_ADDR;
            w_load      = 1'b1;
            w_load_byte = 8'hC0;
          end else if (r_char_idx == 5'd31) begin
            w_frame_done_nxt = 1'b1;
            w_state_nxt      = S_ADDR;
            w_load           = 1'b1;
            w_load_byte      = 8'h80;
          end else begin
            w_state_nxt = S_FETCH;
            w_sel_nxt   = r_char_idx + 5'd1;
          end
        end
      endcase
    end

    // Every bus write begins here: rs/db only ever change at the start of SETUP
    if (w_load) begin
      w_byte_nxt   = w_load_byte;
      w_single_nxt = w_load_single;
      w_rs_nxt     = w_load_rs;
      w_db_nxt     = NIBBLE ? {w_load_byte[7:4], 4'h0} : w_load_byte;
      w_nib_lo_nxt = 1'b0;
      w_phase_nxt  = P_SETUP;
      w_cnt_nxt    = '0;
    end
  end

  assign buf_sel    = r_sel;
  assign lcd_e      = r_e;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_db     = r_db;
  assign init_done  = r_init_done;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb/tb_lcd_refresh_ctrl.sv - directed bench for lcd_refresh_ctrl (8-bit build, small timing parameters).
module tb_lcd_refresh_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] buf_sel;
  logic [7:0] buf_data;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db;
  logic       init_done;
  logic       frame_done;

  logic [7:0] regfile [32];
  assign buf_data = regfile[buf_sel];

  lcd_refresh_ctrl #(
    .CLK_DIV(2), .CMD_WAIT(4), .CLEAR_WAIT(8), .POWERUP_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .buf_sel(buf_sel), .buf_data(buf_data),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db),
    .init_done(init_done), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  bit   mon_en = 1'b0;
  int   rise_db[$], rise_rs[$], rise_cyc[$], rise_sel[$], fd_cyc[$];
  int   init_cyc = -1;
  int   bad_width = 0, bad_stab = 0, hi_cnt = 0;
  logic [7:0] hi_db;
  logic hi_rs;
  logic prev_e = 1'b0, prev_init = 1'b0;

  // Bus observer: logs each E strobe, its width and whether rs/db stayed put while E was high
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (lcd_e && !prev_e) begin
        rise_db.push_back(int'(lcd_db));
        rise_rs.push_back(int'(lcd_rs));
        rise_cyc.push_back(cyc);
        rise_sel.push_back(int'(buf_sel));
        hi_db  = lcd_db;
        hi_rs  = lcd_rs;
        hi_cnt = 1;
      end else if (lcd_e) begin
        hi_cnt++;
        if (lcd_db !== hi_db || lcd_rs !== hi_rs) bad_stab++;
      end
      if (!lcd_e && prev_e && hi_cnt != 2) bad_width++;
      if (init_done && !prev_init) init_cyc = cyc;
      if (frame_done) fd_cyc.push_back(cyc);
    end
    prev_e    = lcd_e;
    prev_init = init_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic check_init(input string pfx);
    int exp_db [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int exp_cy [6] = '{12, 22, 32, 42, 52, 66};
    for (int t = 0; t < 200 && rise_db.size() < 6; t++) @(negedge clk);
    check({pfx, "_init_rises"}, 32'(rise_db.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("%s_init_db%0d", pfx, k), qget(rise_db, k), exp_db[k]);
      check($sformatf("%s_init_rs%0d", pfx, k), qget(rise_rs, k), 0);
      check($sformatf("%s_init_cyc%0d", pfx, k), qget(rise_cyc, k), exp_cy[k]);
    end
    for (int t = 0; t < 100 && init_cyc < 0; t++) @(negedge clk);
    check({pfx, "_init_done_cyc"}, init_cyc, 74);
    for (int t = 0; t < 600 && fd_cyc.size() < 1; t++) @(negedge clk);
    check({pfx, "_frame_done1_cyc"}, qget(fd_cyc, 0), 446);
  endtask

  initial begin
    int exp_db, exp_rs;
    for (int i = 0; i < 32; i++) regfile[i] = 8'(8'h41 + i);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_e", 32'(lcd_e), 0);
    check("rst_rs", 32'(lcd_rs), 0);
    check("rst_rw", 32'(lcd_rw), 0);
    check("rst_db", 32'(lcd_db), 0);
    check("rst_sel", 32'(buf_sel), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_frame_done", 32'(frame_done), 0);

    rst    = 1'b0;
    mon_en = 1'b1;
    check_init("a");

    check("f1_addr_cyc", qget(rise_cyc, 6), 76);
    check("f1_char0_cyc", qget(rise_cyc, 7), 87);
    for (int k = 0; k < 34; k++) begin
      if (k == 0) begin
        exp_db = 8'h80; exp_rs = 0;
      end else if (k == 17) begin
        exp_db = 8'hC0; exp_rs = 0;
      end else if (k < 17) begin
        exp_db = 8'h41 + k - 1; exp_rs = 1;
      end else begin
        exp_db = 8'h51 + k - 18; exp_rs = 1;
      end
      check($sformatf("f1_db%0d", k), qget(rise_db, 6 + k), exp_db);
      check($sformatf("f1_rs%0d", k), qget(rise_rs, 6 + k), exp_rs);
      if (exp_rs == 1)
        check($sformatf("f1_sel%0d", k), qget(rise_sel, 6 + k), (k < 17) ? k - 1 : k - 2);
    end

    for (int t = 0; t < 200 && buf_sel != 5'd5; t++) @(negedge clk);
    check("f2_sel5_seen", 32'(buf_sel), 5);
    regfile[20] = 8'h7A;
    for (int t = 0; t < 800 && fd_cyc.size() < 2; t++) @(negedge clk);
    check("f2_idx19", qget(rise_db, 61), 8'h54);
    check("f2_idx20_overwrite", qget(rise_db, 62), 8'h7A);
    check("f2_idx21", qget(rise_db, 63), 8'h56);
    check("f2_period", qget(fd_cyc, 1) - qget(fd_cyc, 0), 372);

    for (int t = 0; t < 1200 && fd_cyc.size() < 4; t++) @(negedge clk);
    check("f3_period", qget(fd_cyc, 2) - qget(fd_cyc, 1), 372);
    check("f4_period", qget(fd_cyc, 3) - qget(fd_cyc, 2), 372);
    check("rises_4frames", rise_db.size(), 6 + 4 * 34);
    check("e_width_bad", bad_width, 0);
    check("e_stable_bad", bad_stab, 0);

    for (int t = 0; t < 50 && !(lcd_e && lcd_rs); t++) @(negedge clk);
    check("mid_char_e_high", 32'(lcd_e && lcd_rs), 1);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check("mid_rst_e", 32'(lcd_e), 0);
    check("mid_rst_rs", 32'(lcd_rs), 0);
    check("mid_rst_db", 32'(lcd_db), 0);
    check("mid_rst_sel", 32'(buf_sel), 0);
    check("mid_rst_init_done", 32'(init_done), 0);
    check("mid_rst_frame_done", 32'(frame_done), 0);
    rise_db.delete(); rise_rs.delete(); rise_cyc.delete(); rise_sel.delete(); fd_cyc.delete();
    init_cyc = -1;
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    check_init("b");
    check("b_e_width_bad", bad_width, 0);
    check("b_e_stable_bad", bad_stab, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
